// File: rtl/timer_ctrl_master.sv
// -----------------------------------------------------------------------------
// timer_ctrl_master
//
// Avalon-MM master that drives an interval timer peripheral. It programs the
// timer period and starts it, acknowledges timeouts and counts them, takes
// coherent 32-bit snapshots of the running counter, and stops the timer.
//
// Ports
//   clk, reset_n           clock (rising edge), asynchronous active-low reset
//   start, period          one-cycle request to program period[31:0] and start
//   stop                   one-cycle request to stop the timer
//   snap_req               one-cycle request to snapshot the timer counter
//   irq                    timer interrupt (timeout flag AND interrupt enable)
//   readdata               timer read data, valid one cycle after the address
//   address, chipselect,
//   write_n, writedata     registered Avalon-MM master bus to the timer
//   busy                   high while a bus sequence is in progress
//   tick, tick_count       pulse and wrapping count of acknowledged timeouts
//   snap_value, snap_valid last snapshot and its one-cycle update strobe
// -----------------------------------------------------------------------------
module timer_ctrl_master #(
  parameter bit CONTINUOUS = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] period,
  input  logic        stop,
  input  logic        snap_req,
  input  logic        irq,
  input  logic [15:0] readdata,
  output logic [2:0]  address,
  output logic        chipselect,
  output logic        write_n,
  output logic [15:0] writedata,
  output logic        busy,
  output logic        tick,
  output logic [15:0] tick_count,
  output logic [31:0] snap_value,
  output logic        snap_valid
);

  typedef enum logic [3:0] {
    IDLE, CFG_STOP, CFG_PL, CFG_PH, CFG_GO, RUN, ACK, HALT,
    SNAP_W, SNAP_RL, SNAP_RH, SNAP_CAP
  } state_e;

  typedef struct packed {
    logic [2:0]  addr;
    logic        cs;
    logic        wr_n;
    logic [15:0] wdata;
  } bus_t;

  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_CTRL   = 3'd1;
  localparam logic [2:0] ADDR_PER_L  = 3'd2;
  localparam logic [2:0] ADDR_PER_H  = 3'd3;
  localparam logic [2:0] ADDR_SNAP_L = 3'd4;
  localparam logic [2:0] ADDR_SNAP_H = 3'd5;

  // Control register bits: {stop, start, cont, ito}.
  localparam logic [15:0] CTRL_STOP = 16'h0008;
  localparam logic [15:0] CTRL_GO   = 16'h0005 | {14'd0, CONTINUOUS, 1'b0};

  localparam bus_t BUS_IDLE = '{addr: 3'd0, cs: 1'b0, wr_n: 1'b1, wdata: 16'h0000};

  function automatic bus_t bus_wr(input logic [2:0] a, input logic [15:0] d);
    return '{addr: a, cs: 1'b1, wr_n: 1'b0, wdata: d};
  endfunction

  function automatic bus_t bus_rd(input logic [2:0] a);
    return '{addr: a, cs: 1'b1, wr_n: 1'b1, wdata: 16'h0000};
  endfunction

  state_e      state_q;
  bus_t        bus_q;
  logic [31:0] period_q;
  logic        stop_pend_q;
  logic        snap_pend_q;
  logic        tick_q;
  logic [15:0] tick_count_q;
  logic [15:0] snap_lo_q;
  logic [31:0] snap_value_q;
  logic        snap_valid_q;

  // A request arriving in the same RUN cycle competes as if already pending.
  logic stop_eff;
  logic snap_eff;
  assign stop_eff = stop_pend_q | stop;
  assign snap_eff = snap_pend_q | snap_req;

  // NOTE: every register here, including the latched period and snapshot
  // halves, is reset so that an aborted sequence leaves no stale state behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      bus_q        <= BUS_IDLE;
      period_q     <= '0;
      stop_pend_q  <= 1'b0;
      snap_pend_q  <= 1'b0;
      tick_q       <= 1'b0;
      tick_count_q <= '0;
      snap_lo_q    <= '0;
      snap_value_q <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      // NOTE: these defaults are non-blocking; an assignment further down in
      // the case statement to the same register takes precedence.
      bus_q        <= BUS_IDLE;
      tick_q       <= 1'b0;
      snap_valid_q <= 1'b0;
      if (stop)     stop_pend_q <= 1'b1;
      if (snap_req) snap_pend_q <= 1'b1;

      case (state_q)
        IDLE: begin
          // No timer is running, so pending stop/snapshot have nothing to act on.
          stop_pend_q <= 1'b0;
          snap_pend_q <= 1'b0;
          if (start) begin
            period_q <= period;
            bus_q    <= bus_wr(ADDR_CTRL, CTRL_STOP);
            state_q  <= CFG_STOP;
          end
        end
        CFG_STOP: begin
          bus_q   <= bus_wr(ADDR_PER_L, period_q[15:0]);
          state_q <= CFG_PL;
        end
        CFG_PL: begin
          bus_q   <= bus_wr(ADDR_PER_H, period_q[31:16]);
          state_q <= CFG_PH;
        end
        CFG_PH: begin
          bus_q   <= bus_wr(ADDR_CTRL, CTRL_GO);
          state_q <= CFG_GO;
        end
        CFG_GO: state_q <= RUN;
        RUN: begin
          if (stop_eff) begin
            bus_q   <= bus_wr(ADDR_CTRL, CTRL_STOP);
            state_q <= HALT;
          end else if (irq) begin
            bus_q        <= bus_wr(ADDR_STATUS, 16'h0000);
            tick_q       <= 1'b1;
            tick_count_q <= tick_count_q + 16'd1;
            state_q      <= ACK;
          end else if (snap_eff) begin
            bus_q   <= bus_wr(ADDR_SNAP_L, 16'h0000);
            state_q <= SNAP_W;
          end else if (start) begin
            period_q <= period;
            bus_q    <= bus_wr(ADDR_CTRL, CTRL_STOP);
            state_q  <= CFG_STOP;
          end
        end
        // irq still shows the old flag here; the status write lands this cycle.
        ACK: state_q <= RUN;
        HALT: begin
          stop_pend_q <= 1'b0;
          state_q     <= IDLE;
        end
        SNAP_W: begin
          bus_q   <= bus_rd(ADDR_SNAP_L);
          state_q <= SNAP_RL;
        end
        SNAP_RL: begin
          bus_q   <= bus_rd(ADDR_SNAP_H);
          state_q <= SNAP_RH;
        end
        SNAP_RH: begin
          snap_lo_q <= readdata;
          state_q   <= SNAP_CAP;
        end
        SNAP_CAP: begin
          // Both halves are committed together so readers never see a torn value.
          snap_value_q <= {readdata, snap_lo_q};
          snap_valid_q <= 1'b1;
          snap_pend_q  <= 1'b0;
          state_q      <= RUN;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign address    = bus_q.addr;
  assign chipselect = bus_q.cs;
  assign write_n    = bus_q.wr_n;
  assign writedata  = bus_q.wdata;
  assign busy       = (state_q != IDLE) && (state_q != RUN);
  assign tick       = tick_q;
  assign tick_count = tick_count_q;
  assign snap_value = snap_value_q;
  assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_timer_ctrl_master.sv
// -----------------------------------------------------------------------------
// tb_timer_ctrl_master
//
// Directed bench for timer_ctrl_master with its default CONTINUOUS=1. A small
// timer model holds the timeout flag until a status write and returns the
// snapshot halves one cycle after a read address. Inputs are driven and
// outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_timer_ctrl_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] period = '0;
  logic        stop = 1'b0;
  logic        snap_req = 1'b0;
  logic        irq;
  logic [15:0] readdata = 16'hDEAD;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic        busy;
  logic        tick;
  logic [15:0] tick_count;
  logic [31:0] snap_value;
  logic        snap_valid;

  int vectors = 0;
  int miscompares = 0;

  timer_ctrl_master dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .period     (period),
    .stop       (stop),
    .snap_req   (snap_req),
    .irq        (irq),
    .readdata   (readdata),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .busy       (busy),
    .tick       (tick),
    .tick_count (tick_count),
    .snap_value (snap_value),
    .snap_valid (snap_valid)
  );

  always #5 clk = ~clk;

  // Timer model: timeout flag set by the bench, cleared by a status write.
  logic        to_flag = 1'b0;
  logic        set_timeout = 1'b0;
  logic [15:0] snap_l_m = 16'h0000;
  logic [15:0] snap_h_m = 16'h0000;

  always @(posedge clk) begin
    if (chipselect && !write_n && address == 3'd0) to_flag <= 1'b0;
    else if (set_timeout)                          to_flag <= 1'b1;
    if (chipselect && write_n)
      readdata <= (address == 3'd4) ? snap_l_m :
                  (address == 3'd5) ? snap_h_m : 16'hDEAD;
    else
      readdata <= 16'hDEAD;
  end
  assign irq = to_flag;

  logic [20:0] bus_w;
  assign bus_w = {address, chipselect, write_n, writedata};

  localparam logic [20:0] IDL = {3'd0, 1'b0, 1'b1, 16'h0000};

  function automatic logic [20:0] wr(input logic [2:0] a, input logic [15:0] d);
    return {a, 1'b1, 1'b0, d};
  endfunction

  function automatic logic [20:0] rd(input logic [2:0] a);
    return {a, 1'b1, 1'b1, 16'h0000};
  endfunction

  // Stimulus only: raise one timeout and report what the DUT did over 8 cycles.
  task automatic pulse_timeout(output int writes, output int ticks);
    writes = 0;
    ticks  = 0;
    @(negedge clk); set_timeout = 1'b1;
    @(negedge clk); set_timeout = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (chipselect && !write_n && address == 3'd0 && writedata == 16'h0000) writes++;
      if (tick) ticks++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus_w !== IDL) begin
      miscompares++;
      $display("FAIL reset_bus: got %h want %h", bus_w, IDL);
    end
    vectors++;
    if ({busy, tick, snap_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags: got busy/tick/valid=%b want 000", {busy, tick, snap_valid});
    end
    vectors++;
    if (tick_count !== 16'h0000 || snap_value !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_counts: got count=%h snap=%h want 0000/00000000", tick_count, snap_value);
    end
  endtask

  task automatic test_config();
    logic [21:0] exp[5];
    exp = '{{wr(3'd1, 16'h0008), 1'b1}, {wr(3'd2, 16'h86A0), 1'b1},
            {wr(3'd3, 16'h0001), 1'b1}, {wr(3'd1, 16'h0007), 1'b1}, {IDL, 1'b0}};
    @(negedge clk); start = 1'b1; period = 32'h0001_86A0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); start = 1'b0;
      vectors++;
      if ({bus_w, busy} !== exp[i]) begin
        miscompares++;
        $display("FAIL config[%0d]: got bus=%h busy=%b want bus=%h busy=%b",
                 i, bus_w, busy, exp[i][21:1], exp[i][0]);
      end
    end
  endtask

  task automatic test_timeout();
    int w, t;
    for (int k = 1; k <= 3; k++) begin
      pulse_timeout(w, t);
      vectors++;
      if (w != 1 || t != 1) begin
        miscompares++;
        $display("FAIL timeout[%0d]: got writes=%0d ticks=%0d want 1/1", k, w, t);
      end
      vectors++;
      if (tick_count !== 16'(k)) begin
        miscompares++;
        $display("FAIL timeout_count[%0d]: got %h want %h", k, tick_count, 16'(k));
      end
    end
  endtask

  task automatic test_snapshot();
    logic [54:0] exp[6];
    snap_l_m = 16'h1234;
    snap_h_m = 16'h0005;
    exp = '{{wr(3'd4, 16'h0), 1'b1, 1'b0, 32'h0},
            {rd(3'd4),        1'b1, 1'b0, 32'h0},
            {rd(3'd5),        1'b1, 1'b0, 32'h0},
            {IDL,             1'b1, 1'b0, 32'h0},
            {IDL,             1'b0, 1'b1, 32'h0005_1234},
            {IDL,             1'b0, 1'b0, 32'h0005_1234}};
    @(negedge clk); snap_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); snap_req = 1'b0;
      vectors++;
      if ({bus_w, busy, snap_valid, snap_value} !== exp[i]) begin
        miscompares++;
        $display("FAIL snapshot[%0d]: got bus=%h busy=%b valid=%b value=%h want bus=%h busy=%b valid=%b value=%h",
                 i, bus_w, busy, snap_valid, snap_value,
                 exp[i][54:34], exp[i][33], exp[i][32], exp[i][31:0]);
      end
    end
  endtask

  // stop and irq seen together in RUN: HALT wins, no ACK; irq ignored in IDLE.
  task automatic test_stop_irq();
    logic [22:0] exp[5];
    exp = '{{wr(3'd1, 16'h0008), 1'b1, 1'b0}, {IDL, 1'b0, 1'b0},
            {IDL, 1'b0, 1'b0}, {IDL, 1'b0, 1'b0}, {IDL, 1'b0, 1'b0}};
    @(negedge clk); set_timeout = 1'b1;
    @(negedge clk); set_timeout = 1'b0; stop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); stop = 1'b0;
      vectors++;
      if ({bus_w, busy, tick} !== exp[i]) begin
        miscompares++;
        $display("FAIL stop_irq[%0d]: got bus=%h busy=%b tick=%b want bus=%h busy=%b tick=%b",
                 i, bus_w, busy, tick, exp[i][22:2], exp[i][1], exp[i][0]);
      end
    end
    vectors++;
    if (tick_count !== 16'd3) begin
      miscompares++;
      $display("FAIL stop_irq_count: got %h want 0003", tick_count);
    end
  endtask

  // irq left pending from the previous test must wait out the whole config.
  task automatic test_irq_during_cfg();
    logic [22:0] exp[7];
    exp = '{{wr(3'd1, 16'h0008), 1'b1, 1'b0}, {wr(3'd2, 16'hBEEF), 1'b1, 1'b0},
            {wr(3'd3, 16'hDEAD), 1'b1, 1'b0}, {wr(3'd1, 16'h0007), 1'b1, 1'b0},
            {IDL, 1'b0, 1'b0}, {wr(3'd0, 16'h0000), 1'b1, 1'b1}, {IDL, 1'b0, 1'b0}};
    @(negedge clk); start = 1'b1; period = 32'hDEAD_BEEF;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); start = 1'b0;
      vectors++;
      if ({bus_w, busy, tick} !== exp[i]) begin
        miscompares++;
        $display("FAIL irq_cfg[%0d]: got bus=%h busy=%b tick=%b want bus=%h busy=%b tick=%b",
                 i, bus_w, busy, tick, exp[i][22:2], exp[i][1], exp[i][0]);
      end
    end
    vectors++;
    if (tick_count !== 16'd4) begin
      miscompares++;
      $display("FAIL irq_cfg_count: got %h want 0004", tick_count);
    end
  endtask

  task automatic test_wrap();
    int w, t;
    @(negedge clk); force dut.tick_count_q = 16'hFFFF;
    @(negedge clk); release dut.tick_count_q;
    @(negedge clk);
    vectors++;
    if (tick_count !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL wrap_preload: got %h want ffff", tick_count);
    end
    pulse_timeout(w, t);
    vectors++;
    if (w != 1 || t != 1 || tick_count !== 16'h0000) begin
      miscompares++;
      $display("FAIL wrap: got writes=%0d ticks=%0d count=%h want 1/1/0000", w, t, tick_count);
    end
  endtask

  // Restart from RUN; stop during CFG_PL, a dropped start during CFG_PH.
  task automatic test_stop_during_cfg();
    logic [21:0] exp[8];
    exp = '{{wr(3'd1, 16'h0008), 1'b1}, {wr(3'd2, 16'h0010), 1'b1},
            {wr(3'd3, 16'h0000), 1'b1}, {wr(3'd1, 16'h0007), 1'b1},
            {IDL, 1'b0}, {wr(3'd1, 16'h0008), 1'b1}, {IDL, 1'b0}, {IDL, 1'b0}};
    @(negedge clk); start = 1'b1; period = 32'h0000_0010;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = (i == 2);
      stop  = (i == 1);
      vectors++;
      if ({bus_w, busy} !== exp[i]) begin
        miscompares++;
        $display("FAIL stop_cfg[%0d]: got bus=%h busy=%b want bus=%h busy=%b",
                 i, bus_w, busy, exp[i][21:1], exp[i][0]);
      end
    end
    start = 1'b0;
    stop  = 1'b0;
    vectors++;
    if (tick_count !== 16'h0000) begin
      miscompares++;
      $display("FAIL stop_cfg_count: got %h want 0000", tick_count);
    end
  endtask

  task automatic test_reset_mid_snap();
    int valids, cycles;
    @(negedge clk); start = 1'b1; period = 32'h0000_0100;
    repeat (5) begin
      @(negedge clk); start = 1'b0;
    end
    snap_req = 1'b1;
    @(negedge clk); snap_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus_w !== rd(3'd4)) begin
      miscompares++;
      $display("FAIL mid_snap_setup: got bus=%h want %h", bus_w, rd(3'd4));
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({bus_w, busy, tick, snap_valid} !== {IDL, 3'b000} ||
        tick_count !== 16'h0 || snap_value !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_snap_reset: got bus=%h flags=%b count=%h snap=%h want %h 000 0000 00000000",
               bus_w, {busy, tick, snap_valid}, tick_count, snap_value, IDL);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    valids = 0;
    cycles = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (snap_valid) valids++;
      if (chipselect) cycles++;
    end
    vectors++;
    if (valids != 0 || cycles != 0) begin
      miscompares++;
      $display("FAIL mid_snap_after: got valid_pulses=%0d bus_cycles=%0d want 0/0", valids, cycles);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_config();
    test_timeout();
    test_snapshot();
    test_stop_irq();
    test_irq_during_cfg();
    test_wrap();
    test_stop_during_cfg();
    test_reset_mid_snap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
